// File: rtl/alu_regfile_pipe.sv
// Two-stage (operand read / execute) ALU with register file, forwarding and registered flags.
// Define ALU_MUL_EN to add the iterative shift-add multiplier on opcode 0E.
module alu_regfile_pipe #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 16,
  localparam int RIDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        aluOp,
  input  logic [RIDX_W-1:0] srcA,
  input  logic [RIDX_W-1:0] srcB,
  input  logic [RIDX_W-1:0] dst,
  input  logic [DATA_W-1:0] imm,
  input  logic              immEn,
  input  logic              cin,
  output logic              result_valid,
  output logic [RIDX_W-1:0] regReadNumber,
  output logic [DATA_W-1:0] regReadData,
  output logic [4:0]        flags
);

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDC = 8'h06;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam int         MSB     = DATA_W - 1;

  function automatic logic op_writes(input logic [7:0] op);
    logic w;
    w = (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_ADD) ||
        (op == OP_ADDC) || (op == OP_SUB) || (op == OP_MOV);
`ifdef ALU_MUL_EN
    w = w || (op == OP_MUL);
`endif
    return w;
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              ex_valid;
  logic [7:0]        ex_op;
  logic [RIDX_W-1:0] ex_dst;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic              ex_cin;
  logic              ex_writes;

  logic              accept;
  logic              commit;
  logic              mul_busy;
  logic              in_known;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_res;
  logic [4:0]        alu_flags;
  logic              f_n, f_z, f_f, f_l, f_c;
  logic              is_sub;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W + 1);
  logic [2*DATA_W-1:0] mul_acc;
  logic [2*DATA_W-1:0] mul_mcand;
  logic [DATA_W-1:0]   mul_mplier;
  logic [CNT_W-1:0]    mul_cnt;

  assign mul_busy = ex_valid && (ex_op == OP_MUL) && (mul_cnt != CNT_W'(DATA_W));
`else
  assign mul_busy = 1'b0;
`endif

  assign in_ready  = !mul_busy;
  assign accept    = in_valid && in_ready;
  assign commit    = ex_valid && !mul_busy;
  assign ex_writes = op_writes(ex_op);
  assign in_known  = op_writes(aluOp) || (aluOp == OP_CMP);

  // Operands come from the EX result when EX is about to write the register being read.
  always_comb begin
    opnd_a = regs[srcA];
    opnd_b = regs[srcB];
    if (ex_valid && ex_writes && (ex_dst == srcA)) opnd_a = alu_res;
    if (ex_valid && ex_writes && (ex_dst == srcB)) opnd_b = alu_res;
    if (immEn) opnd_b = imm;
  end

  always_comb begin
    sum     = {1'b0, ex_a} + {1'b0, ex_b} + {{DATA_W{1'b0}}, (ex_op == OP_ADDC) && ex_cin};
    diff    = {1'b0, ex_a} - {1'b0, ex_b};
    alu_res = '0;
    f_f     = 1'b0;
    f_l     = 1'b0;
    f_c     = 1'b0;
    f_n     = 1'b0;
    is_sub  = (ex_op == OP_SUB) || (ex_op == OP_CMP);
    case (ex_op)
      OP_AND:  alu_res = ex_a & ex_b;
      OP_OR:   alu_res = ex_a | ex_b;
      OP_XOR:  alu_res = ex_a ^ ex_b;
      OP_MOV:  alu_res = ex_b;
      OP_ADD, OP_ADDC: begin
        alu_res = sum[MSB:0];
        f_c     = sum[DATA_W];
        f_f     = (ex_a[MSB] == ex_b[MSB]) && (sum[MSB] != ex_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[MSB:0];
        f_c     = diff[DATA_W];
        f_l     = diff[DATA_W];
        f_f     = (ex_a[MSB] != ex_b[MSB]) && (diff[MSB] != ex_a[MSB]);
        f_n     = $signed(ex_a) < $signed(ex_b);
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        alu_res = mul_acc[MSB:0];
        f_c     = |mul_acc[2*DATA_W-1:DATA_W];
      end
`endif
      default: ;
    endcase
    if (!is_sub) f_n = alu_res[MSB];
    f_z       = (alu_res == '0);
    alu_flags = {f_n, f_z, f_f, f_l, f_c};
  end

  // Undefined opcodes are accepted but never occupy EX, so they cannot write or touch flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_dst   <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_cin   <= 1'b0;
    end else if (accept) begin
      ex_valid <= in_known;
      ex_op    <= aluOp;
      ex_dst   <= dst;
      ex_a     <= opnd_a;
      ex_b     <= opnd_b;
      ex_cin   <= cin;
    end else if (commit) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && ex_writes) begin
      regs[ex_dst] <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid  <= 1'b0;
      regReadNumber <= '0;
      regReadData   <= '0;
      flags         <= '0;
    end else begin
      result_valid <= commit && ex_writes;
      if (commit && ex_writes) begin
        regReadNumber <= ex_dst;
        regReadData   <= alu_res;
      end
      if (commit) flags <= alu_flags;
    end
  end

`ifdef ALU_MUL_EN
  // One multiplier bit per cycle; the product is ready once DATA_W steps have run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (accept && (aluOp == OP_MUL)) begin
      mul_acc    <= '0;
      mul_mcand  <= {{DATA_W{1'b0}}, opnd_a};
      mul_mplier <= opnd_b;
      mul_cnt    <= '0;
    end else if (mul_busy) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Self-checking bench for alu_regfile_pipe against a sequential instruction-level model.
// Covers the ALU_MUL_EN build when that macro is defined for the bench as well.
module tb_alu_regfile_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  aluOp;
  logic [3:0]  srcA, srcB, dst;
  logic [15:0] imm;
  logic        immEn;
  logic        cin;
  logic        result_valid;
  logic [3:0]  regReadNumber;
  logic [15:0] regReadData;
  logic [4:0]  flags;

  int checks = 0;
  int fails  = 0;

  logic [15:0] mregs [16];
  logic [4:0]  mflags;
  logic        exp_wr;
  logic [15:0] exp_data;
  logic [3:0]  exp_dst;
  logic [4:0]  exp_flags;

  alu_regfile_pipe #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .srcA(srcA), .srcB(srcB), .dst(dst), .imm(imm),
    .immEn(immEn), .cin(cin), .result_valid(result_valid),
    .regReadNumber(regReadNumber), .regReadData(regReadData), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic model_reset;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
    mflags = 5'b00000;
  endtask

  // Instruction-level semantics; forwarding makes the pipeline equivalent to in-order execution.
  task automatic model_step(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] d, input logic [15:0] im, input logic ie, input logic c);
    int ua, ub, sa, sb, r, s, cc;
    longint p;
    logic   wr;
    logic [4:0] fl;
    ua = int'(mregs[a]);
    ub = ie ? int'(im) : int'(mregs[b]);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    cc = (op == 8'h06 && c) ? 1 : 0;
    wr = 1'b1;
    r  = 0;
    fl = mflags;
    case (op)
      8'h01, 8'h02, 8'h03, 8'h0D: begin
        if (op == 8'h01) r = ua & ub;
        else if (op == 8'h02) r = ua | ub;
        else if (op == 8'h03) r = ua ^ ub;
        else r = ub;
        fl = {(r >= 32768), (r == 0), 3'b000};
      end
      8'h05, 8'h06: begin
        s  = ua + ub + cc;
        r  = s % 65536;
        fl = {(r >= 32768), (r == 0), ((sa + sb + cc) > 32767) || ((sa + sb + cc) < -32768), 1'b0, (s > 65535)};
      end
      8'h09, 8'h0B: begin
        r  = (ua - ub + 65536) % 65536;
        fl = {(sa < sb), (r == 0), ((sa - sb) > 32767) || ((sa - sb) < -32768), (ua < ub), (ua < ub)};
        if (op == 8'h0B) wr = 1'b0;
      end
`ifdef ALU_MUL_EN
      8'h0E: begin
        p  = longint'(ua) * longint'(ub);
        r  = int'(p % 65536);
        fl = {(r >= 32768), (r == 0), 2'b00, (p >= 65536)};
      end
`endif
      default: wr = 1'b0;
    endcase
    mflags    = fl;
    if (wr) mregs[d] = r[15:0];
    exp_wr    = wr;
    exp_data  = r[15:0];
    exp_dst   = d;
    exp_flags = fl;
  endtask

  task automatic drive(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [15:0] im, input logic ie, input logic c);
    in_valid = 1'b1; aluOp = op; srcA = a; srcB = b; dst = d; imm = im; immEn = ie; cin = c;
  endtask

  task automatic issue(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [15:0] im, input logic ie, input logic c);
    @(negedge clk);
    drive(op, a, b, d, im, ie, c);
    model_step(op, a, b, d, im, ie, c);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; aluOp = '0; srcA = '0; srcB = '0; dst = '0;
    imm = '0; immEn = 1'b0; cin = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || regReadNumber !== 4'd0 || regReadData !== 16'h0000 ||
        flags !== 5'b00000 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_state: rv=%b num=%0d data=%h flags=%b ready=%b, required 0/0/0000/00000/1",
               result_valid, regReadNumber, regReadData, flags, in_ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    for (int t = 0; t < 2; t++) begin
      issue(8'h05, 4'd3, 4'd0, (t == 0) ? 4'd0 : 4'd1, (t == 0) ? 16'h1234 : 16'h1111, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL basic_latency[%0d]: rv=%b required 0", t, result_valid);
      end
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || regReadNumber !== exp_dst || regReadData !== exp_data) begin
        fails++;
        $display("[TB] FAIL basic_write[%0d]: rv=%b num=%0d data=%h, required 1/%0d/%h",
                 t, result_valid, regReadNumber, regReadData, exp_dst, exp_data);
      end
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL basic_pulse[%0d]: rv=%b required 0", t, result_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d1;
    @(negedge clk);
    drive(8'h05, 4'd0, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0);
    model_step(8'h05, 4'd0, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0);
    d1 = exp_data;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_ready: in_ready=%b required 1", in_ready);
    end
    drive(8'h09, 4'd2, 4'd1, 4'd3, 16'h0000, 1'b0, 1'b0);
    model_step(8'h09, 4'd2, 4'd1, 4'd3, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || regReadNumber !== 4'd2 || regReadData !== d1) begin
      fails++;
      $display("[TB] FAIL b2b_first: rv=%b num=%0d data=%h, required 1/2/%h", result_valid, regReadNumber, regReadData, d1);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || regReadNumber !== 4'd3 || regReadData !== exp_data) begin
      fails++;
      $display("[TB] FAIL b2b_forward: rv=%b num=%0d data=%h, required 1/3/%h", result_valid, regReadNumber, regReadData, exp_data);
    end
  endtask

  task automatic test_flags;
    logic [7:0]  t_op [6] = '{8'h0D, 8'h0B, 8'h0D, 8'h05, 8'h0D, 8'h06};
    logic [3:0]  t_a  [6] = '{4'd0, 4'd4, 4'd0, 4'd5, 4'd0, 4'd7};
    logic [3:0]  t_d  [6] = '{4'd4, 4'd9, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [15:0] t_im [6] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0000};
    for (int t = 0; t < 6; t++) begin
      issue(t_op[t], t_a[t], 4'd0, t_d[t], t_im[t], 1'b1, (t == 5));
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (result_valid !== exp_wr || (exp_wr && regReadData !== exp_data)) begin
        fails++;
        $display("[TB] FAIL flags_write[%0d]: rv=%b data=%h, required %b/%h", t, result_valid, regReadData, exp_wr, exp_data);
      end
      checks++;
      if (flags !== exp_flags) begin
        fails++; $display("[TB] FAIL flags_value[%0d]: flags=%b required %b", t, flags, exp_flags);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0]  ops [12];
    logic        wr_q [$];
    logic [15:0] data_q [$];
    logic [3:0]  dst_q [$];
    logic [4:0]  fl_q [$];
    logic [7:0]  op;
    logic [3:0]  a, b, d;
    logic [15:0] im;
    logic        ie, c;
    ops = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0B, 8'h0D, 8'h00, 8'h07, 8'hFF, 8'h0E};
`ifdef ALU_MUL_EN
    ops[11] = 8'h0F;
`endif
    for (int burst = 0; burst < 4; burst++) begin
      wr_q.delete(); data_q.delete(); dst_q.delete(); fl_q.delete();
      for (int i = 0; i < 26; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          checks++;
          if (result_valid !== wr_q[i-2] || (wr_q[i-2] && (regReadNumber !== dst_q[i-2] || regReadData !== data_q[i-2]))) begin
            fails++;
            $display("[TB] FAIL rand_write[%0d.%0d]: rv=%b num=%0d data=%h, required %b/%0d/%h",
                     burst, i-2, result_valid, regReadNumber, regReadData, wr_q[i-2], dst_q[i-2], data_q[i-2]);
          end
          checks++;
          if (flags !== fl_q[i-2]) begin
            fails++; $display("[TB] FAIL rand_flags[%0d.%0d]: flags=%b required %b", burst, i-2, flags, fl_q[i-2]);
          end
        end
        if (i < 24) begin
          checks++;
          if (in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL rand_ready[%0d.%0d]: in_ready=%b required 1", burst, i, in_ready);
          end
          op = ops[$urandom_range(0, 11)];
          a  = 4'($urandom_range(0, 15));
          b  = 4'($urandom_range(0, 15));
          d  = 4'($urandom_range(0, 15));
          im = 16'($urandom);
          ie = 1'($urandom_range(0, 1));
          c  = 1'($urandom_range(0, 1));
          drive(op, a, b, d, im, ie, c);
          model_step(op, a, b, d, im, ie, c);
          wr_q.push_back(exp_wr); data_q.push_back(exp_data); dst_q.push_back(exp_dst); fl_q.push_back(exp_flags);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    issue(8'h05, 4'd0, 4'd0, 4'd1, 16'h0005, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || regReadData !== 16'h0000 || flags !== 5'b00000 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid_outputs: rv=%b data=%h flags=%b ready=%b, required 0/0000/00000/1",
               result_valid, regReadData, flags, in_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (4) begin @(negedge clk); if (result_valid === 1'b1) pulses++; end
    checks++;
    if (pulses !== 0) begin
      fails++; $display("[TB] FAIL reset_mid_nowrite: pulses=%0d required 0", pulses);
    end
    issue(8'h0D, 4'd0, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || regReadData !== exp_data) begin
      fails++; $display("[TB] FAIL reset_mid_cleared: rv=%b data=%h required 1/%h", result_valid, regReadData, exp_data);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    int n, pulses;
    logic [15:0] mul_data;
    logic [4:0]  mul_flags;
    issue(8'h0D, 4'd0, 4'd0, 4'd9, 16'h0100, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    issue(8'h0E, 4'd9, 4'd0, 4'd10, 16'h0101, 1'b1, 1'b0);
    mul_data = exp_data; mul_flags = exp_flags;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== 16) begin
      fails++; $display("[TB] FAIL mul_stall: in_ready low for %0d cycles, required 16", n);
    end
    drive(8'h05, 4'd10, 4'd0, 4'd11, 16'h0000, 1'b1, 1'b0);
    model_step(8'h05, 4'd10, 4'd0, 4'd11, 16'h0000, 1'b1, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || regReadNumber !== 4'd10 || regReadData !== mul_data || flags !== mul_flags) begin
      fails++;
      $display("[TB] FAIL mul_write: rv=%b num=%0d data=%h flags=%b, required 1/10/%h/%b",
               result_valid, regReadNumber, regReadData, flags, mul_data, mul_flags);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || regReadNumber !== 4'd11 || regReadData !== exp_data) begin
      fails++;
      $display("[TB] FAIL mul_forward: rv=%b num=%0d data=%h, required 1/11/%h", result_valid, regReadNumber, regReadData, exp_data);
    end
    issue(8'h0E, 4'd9, 4'd0, 4'd12, 16'h0003, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || regReadNumber !== 4'd0 || regReadData !== 16'h0000 ||
        flags !== 5'b00000 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mul_reset_outputs: rv=%b num=%0d data=%h flags=%b ready=%b, required 0/0/0000/00000/1",
               result_valid, regReadNumber, regReadData, flags, in_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (24) begin @(negedge clk); if (result_valid === 1'b1) pulses++; end
    checks++;
    if (pulses !== 0 || in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL mul_reset_nowrite: pulses=%0d ready=%b, required 0/1", pulses, in_ready);
    end
    issue(8'h0D, 4'd0, 4'd9, 4'd13, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || regReadData !== exp_data) begin
      fails++; $display("[TB] FAIL mul_reset_cleared: rv=%b data=%h required 1/%h", result_valid, regReadData, exp_data);
    end
  endtask
`else
  task automatic test_undefined_mul;
    logic [4:0] f_before;
    issue(8'h0D, 4'd0, 4'd0, 4'd9, 16'h8001, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    f_before = exp_flags;
    issue(8'h0E, 4'd9, 4'd0, 4'd10, 16'h0101, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL undef_mul_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || flags !== f_before) begin
      fails++; $display("[TB] FAIL undef_mul_effect: rv=%b flags=%b, required 0/%b", result_valid, flags, f_before);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flags();
    test_random();
    test_reset_mid();
`ifdef ALU_MUL_EN
    test_mul();
`else
    test_undefined_mul();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
